// File: rtl/instr_pkg.sv
// Shared opcode, condition-code and fetch FSM definitions for fetch and decode.
// INSTR_FETCH_SKID_EN selects a two-entry output FIFO instead of a single register.
package instr_pkg;

   localparam logic [3:0] OP_LOAD = 4'h0;
   localparam logic [3:0] OP_AND  = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h4;
   localparam logic [3:0] OP_SUB  = 4'h6;
   localparam logic [3:0] OP_JUMP = 4'h8;
   localparam logic [3:0] OP_JCC  = 4'h9;
   localparam logic [3:0] OP_IN   = 4'hA;
   localparam logic [3:0] OP_OUT  = 4'hE;

   localparam logic [1:0] CC_Z  = 2'b00;
   localparam logic [1:0] CC_NZ = 2'b01;
   localparam logic [1:0] CC_C  = 2'b10;
   localparam logic [1:0] CC_NC = 2'b11;

`ifdef INSTR_FETCH_SKID_EN
   localparam int OB_DEPTH = 2;
`else
   localparam int OB_DEPTH = 1;
`endif

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FETCH_OP  = 3'd1,
      ST_FETCH_ARG = 3'd2,
      ST_ISSUE     = 3'd3,
      ST_WAIT_BR   = 3'd4
   } fetch_state_e;

   typedef struct packed {
      logic [7:0] opcode;
      logic [7:0] operand;
      logic       illegal;
   } instr_t;

   function automatic logic is_two_byte(input logic [7:0] op);
      unique case (op[7:4])
         OP_LOAD, OP_AND, OP_ADD, OP_SUB, OP_JUMP, OP_JCC: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic is_legal(input logic [7:0] op);
      return is_two_byte(op) || op[7:4] == OP_IN || op[7:4] == OP_OUT;
   endfunction

   function automatic logic is_ctrl(input logic [7:0] op);
      return op[7:4] == OP_JUMP || op[7:4] == OP_JCC;
   endfunction

endpackage

// File: rtl/instr_out_buf.sv
// Valid/ready output buffer of depth 1 or 2 holding issued instructions.
module instr_out_buf
   import instr_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_push,
   input  instr_t     i_data,
   input  logic       i_ready,
   output logic       o_valid,
   output logic       o_full,
   output logic [1:0] o_count,
   output instr_t     o_data
);

   localparam logic [1:0] LP_DEPTH = 2'(DEPTH);

   instr_t     r_mem [2];
   logic       r_rd;
   logic       r_wr;
   logic [1:0] r_cnt;
   logic       w_pop;

   assign w_pop   = (r_cnt != 2'd0) && i_ready;
   assign o_valid = (r_cnt != 2'd0);
   assign o_full  = (r_cnt == LP_DEPTH);
   assign o_count = r_cnt;
   assign o_data  = r_mem[r_rd];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_rd     <= 1'b0;
         r_wr     <= 1'b0;
         r_cnt    <= 2'd0;
      end else begin
         if (i_push) begin
            r_mem[r_wr] <= i_data;
            if (DEPTH > 1) r_wr <= ~r_wr;
         end
         if (w_pop && DEPTH > 1) r_rd <= ~r_rd;
         r_cnt <= r_cnt + 2'(i_push) - 2'(w_pop);
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, reads opcode/operand bytes, issues to decode.
module instr_fetch_unit
   import instr_pkg::*;
#(
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   output logic       mem_req,
   output logic [7:0] mem_addr,
   input  logic       mem_ack,
   input  logic [7:0] mem_rdata,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_opcode,
   output logic [7:0] out_operand,
   output logic       out_illegal,
   input  logic       br_resolve,
   input  logic       br_taken
);

   fetch_state_e r_state, w_next;
   logic [7:0]   r_pc, r_op, r_arg;
   logic         r_req;
   logic         w_ack, w_push, w_pop, w_full, w_ld_tgt;
   logic [1:0]   w_cnt;
   fetch_state_e w_cont;
   instr_t       w_data, w_head;

   // an ack only counts while a request is actually outstanding
   assign w_ack    = r_req & mem_ack;
   assign w_pop    = out_valid & out_ready;
   assign w_cont   = run ? ST_FETCH_OP : ST_IDLE;
   assign mem_req  = r_req;
   assign mem_addr = r_pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      w_push   = 1'b0;
      w_data   = '0;
      w_ld_tgt = 1'b0;
      unique case (r_state)
         ST_IDLE: if (run) w_next = ST_FETCH_OP;
         ST_FETCH_OP: if (w_ack) begin
            if (is_two_byte(mem_rdata)) begin
               w_next = ST_FETCH_ARG;
            end else begin
               w_push = 1'b1;
               w_data = {mem_rdata, 8'h00, ~is_legal(mem_rdata)};
               w_next = ST_ISSUE;
            end
         end
         ST_FETCH_ARG: if (w_ack) begin
            w_push = 1'b1;
            w_data = {r_op, mem_rdata, 1'b0};
            w_next = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (is_ctrl(r_op)) begin
               if (w_pop && w_cnt == 2'd1) begin
                  if (r_op[7:4] == OP_JCC) begin
                     w_next = ST_WAIT_BR;
                  end else begin
                     w_ld_tgt = 1'b1;
                     w_next   = w_cont;
                  end
               end
            end else if (w_pop || !w_full) begin
               w_next = w_cont;
            end
         end
         ST_WAIT_BR: if (br_resolve) begin
            w_ld_tgt = br_taken;
            w_next   = w_cont;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc  <= RESET_PC;
         r_req <= 1'b0;
         r_op  <= 8'h00;
         r_arg <= 8'h00;
      end else begin
         if (r_state == ST_FETCH_OP || r_state == ST_FETCH_ARG)
            r_req <= ~w_ack;
         else
            r_req <= 1'b0;
         if (w_ack) r_pc <= r_pc + 8'd1;
         else if (w_ld_tgt) r_pc <= r_arg;
         if (w_ack && r_state == ST_FETCH_OP)  r_op  <= mem_rdata;
         if (w_ack && r_state == ST_FETCH_ARG) r_arg <= mem_rdata;
      end
   end

   instr_out_buf #(.DEPTH(OB_DEPTH)) u_obuf (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_data  (w_data),
      .i_ready (out_ready),
      .o_valid (out_valid),
      .o_full  (w_full),
      .o_count (w_cnt),
      .o_data  (w_head)
   );

   assign out_opcode  = w_head.opcode;
   assign out_operand = w_head.operand;
   assign out_illegal = w_head.illegal;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a zero-wait program memory model.
module tb_instr_fetch_unit;

`ifdef INSTR_FETCH_SKID_EN
   localparam int STALL_EXTRA = 1;
`else
   localparam int STALL_EXTRA = 0;
`endif

   logic       clk, rst_n, run, mem_req, mem_ack, out_valid, out_ready;
   logic       out_illegal, br_resolve, br_taken, hold_ack;
   logic [7:0] mem_addr, mem_rdata, out_opcode, out_operand;
   logic [7:0] mem [256];
   logic [7:0] addr_log [$];
   int checks = 0;
   int errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   instr_fetch_unit #(.RESET_PC(8'h10)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .run         (run),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_opcode  (out_opcode),
      .out_operand (out_operand),
      .out_illegal (out_illegal),
      .br_resolve  (br_resolve),
      .br_taken    (br_taken)
   );

   always @(posedge clk) begin
      if (!rst_n) begin
         mem_ack   <= 1'b0;
         mem_rdata <= 8'h00;
      end else begin
         mem_ack <= 1'b0;
         if (mem_req && !mem_ack && !hold_ack) begin
            mem_ack   <= 1'b1;
            mem_rdata <= mem[mem_addr];
            addr_log.push_back(mem_addr);
         end
      end
   end

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (out_valid) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic handshake;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({mem_req, mem_addr, out_valid, out_opcode, out_operand, out_illegal}
          !== {1'b0, 8'h10, 1'b0, 8'h00, 8'h00, 1'b0}) begin
         errors++;
         $display("FAIL reset got req=%b addr=%h v=%b op=%h arg=%h ill=%b want 0 10 0 00 00 0",
                  mem_req, mem_addr, out_valid, out_opcode, out_operand, out_illegal);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic;
      bit ok;
      wait_valid(ok);
      checks++;
      if (!ok || {out_opcode, out_operand, out_illegal} !== {8'h40, 8'h05, 1'b0}) begin
         errors++;
         $display("FAIL basic_issue got %h/%h/%b want 40/05/0", out_opcode, out_operand, out_illegal);
      end
      checks++;
      if (addr_log.size() < 2 || addr_log[0] !== 8'h10 || addr_log[1] !== 8'h11) begin
         errors++;
         $display("FAIL basic_addr got n=%0d want 10,11", addr_log.size());
      end
      handshake();
   endtask

   task automatic test_jump;
      bit ok;
      wait_valid(ok);
      checks++;
      if (!ok || {out_opcode, out_operand} !== {8'h80, 8'h20}) begin
         errors++;
         $display("FAIL jump1 got %h/%h want 80/20", out_opcode, out_operand);
      end
      checks++;
      if (addr_log.size() < 3 || addr_log[2] !== 8'h12) begin
         errors++;
         $display("FAIL next_addr got n=%0d want 12 at index 2", addr_log.size());
      end
      handshake();
      wait_valid(ok);
      checks++;
      if (!ok || {out_opcode, out_operand} !== {8'h80, 8'h30}) begin
         errors++;
         $display("FAIL jump2 got %h/%h want 80/30", out_opcode, out_operand);
      end
      handshake();
      wait_valid(ok);
      checks++;
      if (!ok || {out_opcode, out_operand} !== {8'h80, 8'hFF}) begin
         errors++;
         $display("FAIL jump3 got %h/%h want 80/FF", out_opcode, out_operand);
      end
      checks++;
      if (addr_log.size() < 7 || addr_log[4] !== 8'h20 || addr_log[5] !== 8'h21
          || addr_log[6] !== 8'h30) begin
         errors++;
         $display("FAIL jump_target got %h want 30 after 20,21", addr_log[6]);
      end
      handshake();
      wait_valid(ok);
      checks++;
      if (!ok || {out_opcode, out_operand} !== {8'h90, 8'h60}) begin
         errors++;
         $display("FAIL wrap_issue got %h/%h want 90/60", out_opcode, out_operand);
      end
      checks++;
      if (addr_log.size() < 10 || addr_log[8] !== 8'hFF || addr_log[9] !== 8'h00) begin
         errors++;
         $display("FAIL wrap_addr got %h,%h want FF,00", addr_log[8], addr_log[9]);
      end
   endtask

   task automatic test_branch;
      bit ok, bad;
      br_resolve = 1'b1;
      br_taken   = 1'b1;
      handshake();
      br_resolve = 1'b0;
      br_taken   = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (mem_req !== 1'b0 || out_valid !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL br_hold got mem_req=%b while waiting want 0", mem_req);
      end
      br_resolve = 1'b1;
      handshake();
      br_resolve = 1'b0;
      wait_valid(ok);
      checks++;
      if (!ok || {out_opcode, out_operand} !== {8'h94, 8'h50}) begin
         errors++;
         $display("FAIL jcc2 got %h/%h want 94/50", out_opcode, out_operand);
      end
      checks++;
      if (addr_log.size() < 11 || addr_log[10] !== 8'h01) begin
         errors++;
         $display("FAIL not_taken_addr got %h want 01", addr_log[10]);
      end
      handshake();
      @(negedge clk);
      @(negedge clk);
      br_resolve = 1'b1;
      br_taken   = 1'b1;
      handshake();
      br_resolve = 1'b0;
      br_taken   = 1'b0;
      wait_valid(ok);
      checks++;
      if (!ok || {out_opcode, out_operand} !== {8'h94, 8'h70}) begin
         errors++;
         $display("FAIL jcc3 got %h/%h want 94/70", out_opcode, out_operand);
      end
      checks++;
      if (addr_log.size() < 13 || addr_log[12] !== 8'h50) begin
         errors++;
         $display("FAIL taken_addr got %h want 50", addr_log[12]);
      end
      handshake();
      @(negedge clk);
      br_resolve = 1'b1;
      handshake();
      br_resolve = 1'b0;
      wait_valid(ok);
      checks++;
      if (!ok || {out_opcode, out_operand, out_illegal} !== {8'hA0, 8'h00, 1'b0}) begin
         errors++;
         $display("FAIL in_op got %h/%h/%b want A0/00/0", out_opcode, out_operand, out_illegal);
      end
      checks++;
      if (addr_log.size() < 15 || addr_log[14] !== 8'h52) begin
         errors++;
         $display("FAIL pc_plus2 got %h want 52", addr_log[14]);
      end
      handshake();
   endtask

   task automatic test_one_byte;
      bit ok;
      wait_valid(ok);
      checks++;
      if (!ok || {out_opcode, out_operand, out_illegal} !== {8'hF3, 8'h00, 1'b1}) begin
         errors++;
         $display("FAIL illegal got %h/%h/%b want F3/00/1", out_opcode, out_operand, out_illegal);
      end
      handshake();
      wait_valid(ok);
      checks++;
      if (!ok || {out_opcode, out_operand, out_illegal} !== {8'hE7, 8'h00, 1'b0}) begin
         errors++;
         $display("FAIL out_op got %h/%h/%b want E7/00/0", out_opcode, out_operand, out_illegal);
      end
      checks++;
      if (addr_log.size() < 17 || addr_log[16] !== 8'h54) begin
         errors++;
         $display("FAIL one_byte_addr got %h want 54", addr_log[16]);
      end
      handshake();
      out_ready = 1'b0;
   endtask

   task automatic test_stall;
      bit ok, bad;
      int n0;
      logic [16:0] snap;
      wait_valid(ok);
      snap = {out_opcode, out_operand, out_illegal};
      n0 = addr_log.size();
      bad = !ok || snap !== {8'h44, 8'h12, 1'b0};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (!out_valid || {out_opcode, out_operand, out_illegal} !== snap) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL stall_stable got %h/%h/%b want 44/12/0 held",
                  out_opcode, out_operand, out_illegal);
      end
      checks++;
      if (addr_log.size() - n0 != STALL_EXTRA) begin
         errors++;
         $display("FAIL stall_fetch got %0d bytes want %0d", addr_log.size() - n0, STALL_EXTRA);
      end
      hold_ack  = 1'b1;
      out_ready = 1'b1;
      handshake();
   endtask

   task automatic test_reset_mid;
      bit ok, seen, bad;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         seen = mem_req;
      end
      checks++;
      if (!seen || mem_addr !== 8'(8'h57 + STALL_EXTRA)) begin
         errors++;
         $display("FAIL pend_addr got req=%b addr=%h want 1 %h", mem_req, mem_addr, 8'h57 + STALL_EXTRA);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({mem_req, mem_addr, out_valid, out_opcode, out_operand, out_illegal}
          !== {1'b0, 8'h10, 1'b0, 8'h00, 8'h00, 1'b0}) begin
         errors++;
         $display("FAIL async_reset got req=%b addr=%h v=%b op=%h want 0 10 0 00",
                  mem_req, mem_addr, out_valid, out_opcode);
      end
      run = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n    = 1'b1;
      hold_ack = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (mem_req !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL idle_run0 got mem_req=1 want 0");
      end
      run = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = mem_req;
      end
      checks++;
      if (!seen || mem_addr !== 8'h10) begin
         errors++;
         $display("FAIL restart_addr got req=%b addr=%h want 1 10", mem_req, mem_addr);
      end
      run = 1'b0;
      wait_valid(ok);
      checks++;
      if (!ok || {out_opcode, out_operand} !== {8'h40, 8'h05}) begin
         errors++;
         $display("FAIL run0_complete got %h/%h want 40/05", out_opcode, out_operand);
      end
      handshake();
      bad = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (mem_req !== 1'b0 || out_valid !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL run0_stop got req=%b v=%b want 0 0", mem_req, out_valid);
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      run        = 1'b1;
      out_ready  = 1'b1;
      br_resolve = 1'b0;
      br_taken   = 1'b0;
      hold_ack   = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 8'hE0;
      mem[8'h10] = 8'h40; mem[8'h11] = 8'h05;
      mem[8'h12] = 8'h80; mem[8'h13] = 8'h20;
      mem[8'h20] = 8'h80; mem[8'h21] = 8'h30;
      mem[8'h30] = 8'h80; mem[8'h31] = 8'hFF;
      mem[8'hFF] = 8'h90; mem[8'h00] = 8'h60;
      mem[8'h01] = 8'h94; mem[8'h02] = 8'h50;
      mem[8'h50] = 8'h94; mem[8'h51] = 8'h70;
      mem[8'h52] = 8'hA0; mem[8'h53] = 8'hF3;
      mem[8'h54] = 8'hE7; mem[8'h55] = 8'h44;
      mem[8'h56] = 8'h12; mem[8'h57] = 8'hA0;
      mem[8'h58] = 8'hA0;
      test_reset();
      test_basic();
      test_jump();
      test_branch();
      test_one_byte();
      test_stall();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
